// File: rtl/cpu_io_seq_pkg.sv
// Shared types and sizing for the CPU_IO operation sequencer.
// Holds the FSM state enum, lane/operand widths, beat count and counter width.
package cpu_io_seq_pkg;

  localparam int LANE_W    = 4;
  localparam int OP_WIDTH  = 32;
  localparam int TIMEOUT_W = 8;

  function automatic int beats_of(input int w, input int l);
    return w / l;
  endfunction

  localparam int BEATS = beats_of(OP_WIDTH, LANE_W);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    RECV,
    DONE
  } state_t;

endpackage

// File: rtl/cpu_io_lane_shifter.sv
// Nibble shift register: parallel load, or shift right by one lane with
// lane_in entering at the top. Ports: clk, rst, load, shift, din, lane_in, q.
module cpu_io_lane_shifter
  import cpu_io_seq_pkg::*;
#(
  parameter int OP_WIDTH = cpu_io_seq_pkg::OP_WIDTH,
  parameter int LANE_W   = cpu_io_seq_pkg::LANE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [OP_WIDTH-1:0] din,
  input  logic [LANE_W-1:0]   lane_in,
  output logic [OP_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {lane_in, q[OP_WIDTH-1:LANE_W]};
    end
  end

endmodule

// File: rtl/cpu_io_op_sequencer.sv
// Serialises two operands onto OPA/OPB lanes, waits, deserialises RES0/RES1.
// Ports: UserCLK, Reset, cmd_*, OPA_O/OPB_O, RES0_I..RES2_I, rsp_*.
// Macro CPU_IO_SEQ_STROBE_EN: WAIT ends on RES2_I[0] strobe, with timeout.
module cpu_io_op_sequencer
  import cpu_io_seq_pkg::*;
#(
  parameter int OP_WIDTH = cpu_io_seq_pkg::OP_WIDTH,
  parameter int LANE_W   = cpu_io_seq_pkg::LANE_W,
  parameter int TIMEOUT  = 255
) (
  input  logic                  UserCLK,
  input  logic                  Reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [OP_WIDTH-1:0]   cmd_op_a,
  input  logic [OP_WIDTH-1:0]   cmd_op_b,
  input  logic [7:0]            cmd_latency,
  output logic [LANE_W-1:0]     OPA_O,
  output logic [LANE_W-1:0]     OPB_O,
  input  logic [LANE_W-1:0]     RES0_I,
  input  logic [LANE_W-1:0]     RES1_I,
  input  logic [LANE_W-1:0]     RES2_I,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*OP_WIDTH-1:0] rsp_data,
  output logic [LANE_W-1:0]     rsp_flags,
  output logic                  rsp_err
);

  localparam int NBEATS = beats_of(OP_WIDTH, LANE_W);
  localparam logic [TIMEOUT_W-1:0] LAST_BEAT =
    TIMEOUT_W'(NBEATS - 1);

  state_t               state;
  state_t               state_n;
  logic [TIMEOUT_W-1:0] cnt;
  logic [TIMEOUT_W-1:0] cnt_n;
  logic [7:0]           lat;
  logic                 load;
  logic                 op_shift;
  logic                 res_shift;
  logic                 cap;
  logic                 tmo;

  logic [OP_WIDTH-1:0]  opa_q;
  logic [OP_WIDTH-1:0]  opb_q;
  logic [OP_WIDTH-1:0]  res0_q;
  logic [OP_WIDTH-1:0]  res1_q;

  cpu_io_lane_shifter #(.OP_WIDTH(OP_WIDTH), .LANE_W(LANE_W)) u_opa (
    .clk(UserCLK), .rst(Reset), .load(load), .shift(op_shift),
    .din(cmd_op_a), .lane_in('0), .q(opa_q)
  );

  cpu_io_lane_shifter #(.OP_WIDTH(OP_WIDTH), .LANE_W(LANE_W)) u_opb (
    .clk(UserCLK), .rst(Reset), .load(load), .shift(op_shift),
    .din(cmd_op_b), .lane_in('0), .q(opb_q)
  );

  cpu_io_lane_shifter #(.OP_WIDTH(OP_WIDTH), .LANE_W(LANE_W)) u_res0 (
    .clk(UserCLK), .rst(Reset), .load(1'b0), .shift(res_shift),
    .din('0), .lane_in(RES0_I), .q(res0_q)
  );

  cpu_io_lane_shifter #(.OP_WIDTH(OP_WIDTH), .LANE_W(LANE_W)) u_res1 (
    .clk(UserCLK), .rst(Reset), .load(1'b0), .shift(res_shift),
    .din('0), .lane_in(RES1_I), .q(res1_q)
  );

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      lat   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        lat <= cmd_latency;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    load      = 1'b0;
    op_shift  = 1'b0;
    res_shift = 1'b0;
    cap       = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          load    = 1'b1;
          cnt_n   = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        op_shift = 1'b1;
        if (cnt == LAST_BEAT) begin
          cnt_n = '0;
`ifdef CPU_IO_SEQ_STROBE_EN
          state_n = WAIT;
`else
          state_n = (lat == 8'd0) ? RECV : WAIT;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT: begin
`ifdef CPU_IO_SEQ_STROBE_EN
        if (RES2_I[0]) begin
          cnt_n   = '0;
          state_n = RECV;
        end else if (cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
          cnt_n   = '0;
          tmo     = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`else
        if (cnt == TIMEOUT_W'(lat - 8'd1)) begin
          cnt_n   = '0;
          state_n = RECV;
        end else begin
          cnt_n = cnt + 1'b1;
        end
`endif
      end
      RECV: begin
        res_shift = 1'b1;
        if (cnt == LAST_BEAT) begin
          cnt_n   = '0;
          cap     = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_n = IDLE;
        end
      end
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign OPA_O = (state == SEND) ? opa_q[LANE_W-1:0] : '0;
  assign OPB_O = (state == SEND) ? opb_q[LANE_W-1:0] : '0;

  // The final beat is folded in here directly so the response word
  // is complete on the same edge that enters DONE.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else begin
      rsp_valid <= (state_n == DONE);
      if (cap) begin
        rsp_data  <= {RES1_I, res1_q[OP_WIDTH-1:LANE_W],
                      RES0_I, res0_q[OP_WIDTH-1:LANE_W]};
        rsp_flags <= RES2_I;
      end else if (tmo) begin
        rsp_data  <= '0;
        rsp_flags <= '0;
      end
    end
  end

`ifdef CPU_IO_SEQ_STROBE_EN
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      rsp_err <= 1'b0;
    end else if (cap) begin
      rsp_err <= 1'b0;
    end else if (tmo) begin
      rsp_err <= 1'b1;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{lat,
                       opa_q[OP_WIDTH-1:LANE_W],
                       opb_q[OP_WIDTH-1:LANE_W],
                       res0_q[LANE_W-1:0],
                       res1_q[LANE_W-1:0]};
`else
  assign rsp_err = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{opa_q[OP_WIDTH-1:LANE_W],
                       opb_q[OP_WIDTH-1:LANE_W],
                       res0_q[LANE_W-1:0],
                       res1_q[LANE_W-1:0],
                       (TIMEOUT > 0)};
`endif

endmodule

// File: tb/tb_cpu_io_op_sequencer.sv
// Randomised scoreboard bench for cpu_io_op_sequencer.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_cpu_io_op_sequencer;

  localparam int OW  = 32;
  localparam int LW  = 4;
  localparam int NB  = OW / LW;
  localparam int TMO = 255;
`ifdef CPU_IO_SEQ_STROBE_EN
  localparam int LMIN = 1;
`else
  localparam int LMIN = 0;
`endif

  typedef struct {
    logic [2*OW-1:0] data;
    logic [LW-1:0]   flags;
    logic            err;
    int unsigned     cyc;
  } exp_t;

  logic            UserCLK;
  logic            Reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [OW-1:0]   cmd_op_a;
  logic [OW-1:0]   cmd_op_b;
  logic [7:0]      cmd_latency;
  logic [LW-1:0]   OPA_O;
  logic [LW-1:0]   OPB_O;
  logic [LW-1:0]   RES0_I;
  logic [LW-1:0]   RES1_I;
  logic [LW-1:0]   RES2_I;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [2*OW-1:0] rsp_data;
  logic [LW-1:0]   rsp_flags;
  logic            rsp_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  bit          bp_hold = 0;
  exp_t        exp_q[$];

  cpu_io_op_sequencer dut (
    .UserCLK(UserCLK), .Reset(Reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b),
    .cmd_latency(cmd_latency),
    .OPA_O(OPA_O), .OPB_O(OPB_O),
    .RES0_I(RES0_I), .RES1_I(RES1_I), .RES2_I(RES2_I),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  always @(posedge UserCLK) cyc <= cyc + 1;

  always @(posedge UserCLK) begin
    #1;
    rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  bit              in_rsp = 0;
  bit              hs_chk = 0;
  exp_t            m_e;
  logic [2*OW-1:0] h_data;
  logic [LW-1:0]   h_flags;
  logic            h_err;

  always @(negedge UserCLK) begin
    if (!Reset) begin
      if (hs_chk) begin
        chk("ready_after_hs", {cmd_ready, rsp_valid}, 2'b10);
        hs_chk = 0;
      end
      if (rsp_valid) begin
        if (!in_rsp) begin
          if (exp_q.size() == 0) begin
            chk("spurious_rsp", 1, 0);
          end else begin
            m_e = exp_q.pop_front();
            chk("rsp_cycle", cyc, m_e.cyc);
            chk("rsp_data", rsp_data, m_e.data);
            chk("rsp_flags", rsp_flags, m_e.flags);
            chk("rsp_err", rsp_err, m_e.err);
          end
          in_rsp  = 1;
          h_data  = rsp_data;
          h_flags = rsp_flags;
          h_err   = rsp_err;
        end else begin
          chk("rsp_stable",
              {rsp_data, 3'b0, rsp_err},
              {h_data, 3'b0, h_err});
          chk("flags_stable", rsp_flags, h_flags);
        end
        chk("busy_in_done", cmd_ready, 0);
        if (rsp_ready) begin
          in_rsp = 0;
          hs_chk = 1;
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cmd_ready) begin
        ok = 1;
        return;
      end
      @(negedge UserCLK);
    end
    chk("wait_cmd_ready", 0, 1);
  endtask

  task automatic run_op(input logic [OW-1:0] a,
                        input logic [OW-1:0] b,
                        input int l,
                        input logic [OW-1:0] r0,
                        input logic [OW-1:0] r1,
                        input logic [LW-1:0] fl,
                        input bit tmo,
                        input bit bp);
    int   last;
    int   k;
    int   base;
    bit   ok;
    exp_t e;
    logic [LW-1:0] ea;
    logic [LW-1:0] eb;
    wait_ready(ok);
    if (!ok) return;
    bp_hold   = bp;
    cmd_op_a  = a;
    cmd_op_b  = b;
`ifdef CPU_IO_SEQ_STROBE_EN
    cmd_latency = 8'($urandom);
`else
    cmd_latency = 8'(l);
`endif
    cmd_valid = 1;
    last = tmo ? NB + TMO : 2 * NB + l;
    @(negedge UserCLK);
    base = cyc;
    cmd_valid = 0;
    e.data  = tmo ? '0 : {r1, r0};
    e.flags = tmo ? '0 : fl;
    e.err   = tmo;
    e.cyc   = base + last;
    exp_q.push_back(e);
    for (int c = 1; c <= last; c++) begin
      if (c == 3) begin
        cmd_valid   = 1;
        cmd_op_a    = $urandom;
        cmd_op_b    = $urandom;
        cmd_latency = 8'($urandom);
      end
      if (c == 4) cmd_valid = 0;
      ea = (c <= NB) ? LW'(a >> (LW * (c - 1))) : '0;
      eb = (c <= NB) ? LW'(b >> (LW * (c - 1))) : '0;
      chk("opa_lane", OPA_O, ea);
      chk("opb_lane", OPB_O, eb);
      RES0_I = LW'($urandom);
      RES1_I = LW'($urandom);
      RES2_I = LW'($urandom);
`ifdef CPU_IO_SEQ_STROBE_EN
      if (c > NB && (tmo || c <= NB + l))
        RES2_I[0] = (!tmo && c == NB + l);
`endif
      if (!tmo && c > NB + l) begin
        k = c - NB - l - 1;
        RES0_I = r0[LW*k +: LW];
        RES1_I = r1[LW*k +: LW];
        if (k == NB - 1) RES2_I = fl;
      end
      @(negedge UserCLK);
    end
    RES0_I = '0;
    RES1_I = '0;
    RES2_I = '0;
    chk("opa_idle", OPA_O, 0);
    if (bp) begin
      for (int i = 0; i < 10; i++) begin
        chk("bp_valid", rsp_valid, 1);
        if (i == 2) begin
          cmd_valid = 1;
          cmd_op_a  = $urandom;
        end
        if (i == 3) cmd_valid = 0;
        @(negedge UserCLK);
      end
      bp_hold = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    cmd_valid   = 0;
    cmd_op_a    = '0;
    cmd_op_b    = '0;
    cmd_latency = '0;
    RES0_I      = '0;
    RES1_I      = '0;
    RES2_I      = '0;
    rsp_ready   = 0;
    Reset       = 1;
    repeat (3) @(negedge UserCLK);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_lanes", {OPA_O, OPB_O}, 0);
    Reset = 0;
    @(negedge UserCLK);
    chk("idle_cmd_ready", cmd_ready, 1);

    run_op(32'h87654321, 32'hFEDCBA98, 3,
           32'h76543210, 32'h89ABCDEF, 4'h5, 0, 0);
`ifndef CPU_IO_SEQ_STROBE_EN
    run_op($urandom, $urandom, 0,
           $urandom, $urandom, 4'hA, 0, 0);
`endif
    run_op($urandom, $urandom, 2,
           $urandom, $urandom, 4'h3, 0, 1);

    // Reset during SEND: nothing may come out afterwards
    wait_ready(ok);
    cmd_op_a    = 32'h9ABCDEF1;
    cmd_op_b    = 32'h13572468;
    cmd_latency = 8'd1;
    cmd_valid   = 1;
    @(negedge UserCLK);
    cmd_valid = 0;
    repeat (4) @(negedge UserCLK);
    Reset = 1;
    @(negedge UserCLK);
    chk("midrst_opa", OPA_O, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_valid", rsp_valid, 0);
    Reset = 0;
    repeat (40) @(negedge UserCLK);

    repeat (30) begin
      run_op($urandom, $urandom,
             $urandom_range(LMIN, 12),
             $urandom, $urandom,
             LW'($urandom), 0,
             ($urandom_range(0, 7) == 0));
    end

`ifdef CPU_IO_SEQ_STROBE_EN
    run_op($urandom, $urandom, 1,
           $urandom, $urandom, 4'h0, 1, 0);
    run_op($urandom, $urandom, 6,
           $urandom, $urandom, 4'h9, 0, 0);
`endif

    for (int i = 0; i < 500 && exp_q.size() != 0; i++)
      @(negedge UserCLK);
    chk("drain", exp_q.size(), 0);
    repeat (3) @(negedge UserCLK);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
